// File: rtl/lane_surfer_pkg.sv
// -----------------------------------------------------------------------------
// lane_surfer_pkg
// Shared constants and types for the lane-surfer player path.
//   NUM_LANES      : number of lanes, numbered 0..NUM_LANES-1
//   DIR_LEFT/RIGHT : encoding of a queued move direction (1 bit)
//   sched_state_t  : move-scheduler FSM state, with ST_* state constants
// -----------------------------------------------------------------------------
package lane_surfer_pkg;

  localparam int NUM_LANES = 5;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef logic [1:0] sched_state_t;

  localparam sched_state_t ST_IDLE  = 2'd0;
  localparam sched_state_t ST_ISSUE = 2'd1;
  localparam sched_state_t ST_COOL  = 2'd2;

endpackage

// File: rtl/move_fifo.sv
// -----------------------------------------------------------------------------
// move_fifo
// DEPTH x 1-bit FIFO of move directions. Push and pop in the same cycle are
// both honoured, even when full. A push into a full FIFO without a pop is
// dropped. flush empties the FIFO and overrides push/pop.
// Ports:
//   clk, reset (sync, active-low)
//   flush            in   empty the queue this cycle
//   push, push_dir   in   enqueue request and its direction
//   pop              in   dequeue request (ignored when empty)
//   head_dir         out  direction at the queue head
//   count            out  occupancy 0..DEPTH
//   full, empty      out  occupancy flags
// -----------------------------------------------------------------------------
module move_fifo
  import lane_surfer_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          push_dir,
  input  logic          pop,
  output logic          head_dir,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic          mem_q [DEPTH];
  logic          mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign head_dir = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dir;
        wr_ptr_d        = wr_ptr_q + 1'b1;  // power-of-two depth wraps freely
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only read after it
  // has been written, and the pointers/count alone define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/move_scheduler.sv
// -----------------------------------------------------------------------------
// move_scheduler
// Turns button presses into queued lane moves and issues them to the player
// FSM with a fixed cooldown between moves.
// Build option: define MOVE_SCHED_BOUNDARY_EN to suppress moves that would
// leave the lane range (left at lane 0, right at lane NUM_LANES-1); such a
// move is popped without a pulse and skips the cooldown.
// Ports:
//   clk, reset (sync, active-low)
//   btn_left, btn_right  in   synchronized button levels
//   enable               in   game running; low flushes queue, blocks issue
//   lane_in[2:0]         in   current lane (used only with the build option)
//   mv_left, mv_right    out  registered one-cycle move pulses
//   q_count[2:0]         out  queue occupancy
//   busy                 out  FSM not idle
//   overflow             out  sticky: a request was dropped on a full queue
// -----------------------------------------------------------------------------
module move_scheduler
  import lane_surfer_pkg::*;
#(
  parameter int COOLDOWN  = 8,
  parameter int QDEPTH    = 4,
  parameter int NUM_LANES = lane_surfer_pkg::NUM_LANES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       enable,
  input  logic [2:0] lane_in,
  output logic       mv_left,
  output logic       mv_right,
  output logic [2:0] q_count,
  output logic       busy,
  output logic       overflow
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int TW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [TW-1:0] COOL_LOAD = TW'(COOLDOWN - 1);

  sched_state_t  state_q, state_d;
  logic [TW-1:0] cool_q, cool_d;
  logic          btn_l_q, btn_l_d, btn_r_q, btn_r_d;
  logic          mv_left_q, mv_left_d, mv_right_q, mv_right_d;
  logic          overflow_q, overflow_d;

  logic          rise_l, rise_r;
  logic          push_req, push_dir, pop_req;
  logic          head_dir, head_blocked, can_issue, go_issue;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;

  // Simultaneous left and right edges cancel; disabled play ignores buttons.
  assign rise_l   = btn_left  & ~btn_l_q;
  assign rise_r   = btn_right & ~btn_r_q;
  assign push_req = enable & (rise_l ^ rise_r);
  assign push_dir = rise_r ? DIR_RIGHT : DIR_LEFT;
  assign pop_req  = (state_q == ST_ISSUE);
  assign can_issue = enable & ~fifo_empty;

`ifdef MOVE_SCHED_BOUNDARY_EN
  localparam logic [2:0] RIGHT_LANE = 3'(NUM_LANES - 1);
  assign head_blocked = ((head_dir == DIR_LEFT)  && (lane_in == 3'd0)) ||
                        ((head_dir == DIR_RIGHT) && (lane_in == RIGHT_LANE));
`else
  logic unused_lane;
  assign head_blocked = 1'b0;
  assign unused_lane  = ^{lane_in, 3'(NUM_LANES)};
`endif

  move_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (~enable),
    .push     (push_req),
    .push_dir (push_dir),
    .pop      (pop_req),
    .head_dir (head_dir),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    cool_d     = cool_q;
    go_issue   = 1'b0;
    btn_l_d    = btn_left;
    btn_r_d    = btn_right;
    overflow_d = overflow_q | (push_req & fifo_full & ~pop_req);

    case (state_q)
      ST_IDLE: begin
        go_issue = can_issue;
      end
      ST_ISSUE: begin
        // A suppressed boundary move produced no pulse and needs no cooldown.
        if (mv_left_q || mv_right_q) begin
          state_d = ST_COOL;
          cool_d  = COOL_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COOL: begin
        if (cool_q == '0) begin
          if (can_issue) go_issue = 1'b1;
          else           state_d  = ST_IDLE;
        end else begin
          cool_d = cool_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The pulse is registered on the edge entering ISSUE so it is high for
    // exactly the ISSUE cycle; the head is popped at the end of that cycle.
    if (go_issue) state_d = ST_ISSUE;
    mv_left_d  = go_issue && (head_dir == DIR_LEFT)  && !head_blocked;
    mv_right_d = go_issue && (head_dir == DIR_RIGHT) && !head_blocked;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cool_q     <= '0;
      btn_l_q    <= 1'b0;
      btn_r_q    <= 1'b0;
      mv_left_q  <= 1'b0;
      mv_right_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cool_q     <= cool_d;
      btn_l_q    <= btn_l_d;
      btn_r_q    <= btn_r_d;
      mv_left_q  <= mv_left_d;
      mv_right_q <= mv_right_d;
      overflow_q <= overflow_d;
    end
  end

  assign mv_left  = mv_left_q;
  assign mv_right = mv_right_q;
  assign q_count  = 3'(fifo_count);
  assign busy     = (state_q != ST_IDLE);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_move_scheduler.sv
// -----------------------------------------------------------------------------
// tb_move_scheduler
// Directed bench for move_scheduler (COOLDOWN=8, QDEPTH=4, NUM_LANES=5).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Boundary-suppression expectations follow MOVE_SCHED_BOUNDARY_EN.
// -----------------------------------------------------------------------------
module tb_move_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_left, btn_right, enable;
  logic [2:0] lane_in;
  logic       mv_left, mv_right, busy, overflow;
  logic [2:0] q_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  move_scheduler #(.COOLDOWN(8), .QDEPTH(4), .NUM_LANES(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .enable    (enable),
    .lane_in   (lane_in),
    .mv_left   (mv_left),
    .mv_right  (mv_right),
    .q_count   (q_count),
    .busy      (busy),
    .overflow  (overflow)
  );

  // Both pulses must never be high together.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      checks++;
      if (mv_left && mv_right) begin
        errors++;
        $display("FAIL both_pulses: mv_left=%0b mv_right=%0b required not both 1", mv_left, mv_right);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; btn_left = 1'b0; btn_right = 1'b0; enable = 1'b1; lane_in = 3'd2;
    step(); step();
    checks++;
    if ({mv_left, mv_right, q_count, busy, overflow} !== 7'b0) begin
      errors++;
      $display("FAIL reset_hold: outputs=%b required 0000000", {mv_left, mv_right, q_count, busy, overflow});
    end
    reset = 1'b1;
    step();
    checks++;
    if ({mv_left, mv_right, q_count, busy, overflow} !== 7'b0) begin
      errors++;
      $display("FAIL reset_release: outputs=%b required 0000000", {mv_left, mv_right, q_count, busy, overflow});
    end
  endtask

  task automatic test_single_right();
    int pulses = 0;
    btn_right = 1'b1; step(); btn_right = 1'b0;
    checks++;
    if (q_count !== 3'd1 || mv_right !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_push: q_count=%0d mv_right=%0b busy=%0b required 1 0 0", q_count, mv_right, busy);
    end
    step();
    checks++;
    if (mv_right !== 1'b1 || mv_left !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_pulse: mv_right=%0b mv_left=%0b busy=%0b required 1 0 1", mv_right, mv_left, busy);
    end
    step();
    checks++;
    if (mv_right !== 1'b0 || q_count !== 3'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_after: mv_right=%0b q_count=%0d busy=%0b required 0 0 1", mv_right, q_count, busy);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      if (mv_right || mv_left) pulses++;
    end
    checks++;
    if (pulses !== 0 || q_count !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_quiet: pulses=%0d q_count=%0d busy=%0b required 0 0 0", pulses, q_count, busy);
    end
  endtask

  task automatic test_overflow();
    int  pulses = 0;
    logic exp_r;
    for (int i = 0; i < 60; i++) begin
      btn_right = (i <= 10) && (i % 2 == 0);
      step();
      exp_r = (i == 1) || (i == 10) || (i == 19) || (i == 28) || (i == 37);
      if (mv_right) pulses++;
      checks++;
      if (mv_right !== exp_r || mv_left !== 1'b0) begin
        errors++;
        $display("FAIL ovf_pulse_at_%0d: mv_right=%0b mv_left=%0b required %0b 0", i, mv_right, mv_left, exp_r);
      end
      if (i == 8) begin
        checks++;
        if (q_count !== 3'd4) begin
          errors++;
          $display("FAIL ovf_full: q_count=%0d required 4", q_count);
        end
      end
      if (i == 9) begin
        checks++;
        if (overflow !== 1'b0) begin
          errors++;
          $display("FAIL ovf_early: overflow=%0b required 0", overflow);
        end
      end
      if (i == 10) begin
        checks++;
        if (overflow !== 1'b1 || q_count !== 3'd4) begin
          errors++;
          $display("FAIL ovf_drop: overflow=%0b q_count=%0d required 1 4", overflow, q_count);
        end
      end
    end
    btn_right = 1'b0;
    checks++;
    if (pulses !== 5 || overflow !== 1'b1 || q_count !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ovf_end: pulses=%0d overflow=%0b q_count=%0d busy=%0b required 5 1 0 0",
               pulses, overflow, q_count, busy);
    end
  endtask

  task automatic test_boundary();
    lane_in = 3'd0;
    btn_left = 1'b1; step(); btn_left = 1'b0;
    checks++;
    if (q_count !== 3'd1) begin
      errors++;
      $display("FAIL bnd_push: q_count=%0d required 1", q_count);
    end
    step();
`ifdef MOVE_SCHED_BOUNDARY_EN
    checks++;
    if (mv_left !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bnd_left_blocked: mv_left=%0b busy=%0b required 0 1", mv_left, busy);
    end
    step();
    checks++;
    if (busy !== 1'b0 || q_count !== 3'd0) begin
      errors++;
      $display("FAIL bnd_no_cool: busy=%0b q_count=%0d required 0 0", busy, q_count);
    end
`else
    checks++;
    if (mv_left !== 1'b1) begin
      errors++;
      $display("FAIL bnd_left_pulse: mv_left=%0b required 1", mv_left);
    end
    step();
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL bnd_cool_end: busy=%0b required 0", busy);
    end
`endif
    btn_right = 1'b1; step(); btn_right = 1'b0;
    step();
    checks++;
    if (mv_right !== 1'b1) begin
      errors++;
      $display("FAIL bnd_right_from_0: mv_right=%0b required 1", mv_right);
    end
    for (int i = 0; i < 10; i++) step();
    lane_in = 3'd4;
    btn_right = 1'b1; step(); btn_right = 1'b0;
    step();
    checks++;
`ifdef MOVE_SCHED_BOUNDARY_EN
    if (mv_right !== 1'b0) begin
      errors++;
      $display("FAIL bnd_right_blocked: mv_right=%0b required 0", mv_right);
    end
`else
    if (mv_right !== 1'b1) begin
      errors++;
      $display("FAIL bnd_right_pulse: mv_right=%0b required 1", mv_right);
    end
`endif
    for (int i = 0; i < 10; i++) step();
    lane_in = 3'd2;
  endtask

  task automatic test_cancel();
    btn_left = 1'b1; btn_right = 1'b1; step();
    checks++;
    if (q_count !== 3'd0) begin
      errors++;
      $display("FAIL cancel_push: q_count=%0d required 0", q_count);
    end
    step();
    checks++;
    if (mv_left !== 1'b0 || mv_right !== 1'b0 || busy !== 1'b0 || q_count !== 3'd0) begin
      errors++;
      $display("FAIL cancel_idle: mv_left=%0b mv_right=%0b busy=%0b q_count=%0d required 0 0 0 0",
               mv_left, mv_right, busy, q_count);
    end
    btn_left = 1'b0; btn_right = 1'b0; step();
  endtask

  task automatic test_enable_drop();
    int late_pulses = 0;
    for (int i = 0; i <= 30; i++) begin
      btn_right = ((i <= 6) && (i % 2 == 0)) || (i == 14);
      enable    = (i < 8);
      step();
      if (i >= 2 && (mv_right || mv_left)) late_pulses++;
      if (i == 1) begin
        checks++;
        if (mv_right !== 1'b1) begin
          errors++;
          $display("FAIL en_first_pulse: mv_right=%0b required 1", mv_right);
        end
      end
      if (i == 6) begin
        checks++;
        if (q_count !== 3'd3) begin
          errors++;
          $display("FAIL en_queued: q_count=%0d required 3", q_count);
        end
      end
      if (i == 8 || i == 14) begin
        checks++;
        if (q_count !== 3'd0) begin
          errors++;
          $display("FAIL en_flush_at_%0d: q_count=%0d required 0", i, q_count);
        end
      end
      if (i == 9 || i == 10) begin
        checks++;
        if (busy !== (i == 9)) begin
          errors++;
          $display("FAIL en_busy_at_%0d: busy=%0b required %0b", i, busy, (i == 9));
        end
      end
    end
    checks++;
    if (late_pulses !== 0) begin
      errors++;
      $display("FAIL en_no_pulses: pulses=%0d required 0", late_pulses);
    end
    btn_right = 1'b0; enable = 1'b1; step();
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    btn_right = 1'b1; step(); btn_right = 1'b0;
    step();
    reset = 1'b0; step();
    checks++;
    if ({mv_left, mv_right, q_count, busy, overflow} !== 7'b0) begin
      errors++;
      $display("FAIL rst_mid_issue: outputs=%b required 0000000", {mv_left, mv_right, q_count, busy, overflow});
    end
    reset = 1'b1; step(); step();
    checks++;
    if (mv_right !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_issue_after: mv_right=%0b busy=%0b required 0 0", mv_right, busy);
    end
    for (int i = 0; i <= 5; i++) begin
      btn_right = (i <= 4) && (i % 2 == 0);
      step();
    end
    checks++;
    if (q_count !== 3'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_cool_setup: q_count=%0d busy=%0b required 2 1", q_count, busy);
    end
    reset = 1'b0; step();
    checks++;
    if (q_count !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_cool: q_count=%0d busy=%0b required 0 0", q_count, busy);
    end
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (mv_right || mv_left) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL rst_discard: pulses=%0d required 0", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_single_right();
    test_overflow();
    test_boundary();
    test_cancel();
    test_enable_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/move_scheduler.md
MOVE_SCHEDULER -- requirements
Module: move_scheduler

Interface
REQ-001 Parameter COOLDOWN, default 8: idle cycles enforced after each issued move.
REQ-002 Parameter QDEPTH, default 4: move-queue depth in entries, power of two, at least 2.
REQ-003 Parameter NUM_LANES, default 5: number of lanes; lanes are numbered 0..NUM_LANES-1.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 btn_left, btn_right  in  1 each  already-synchronized button levels.
REQ-007 enable  in  1  game running; low pauses issue and flushes the queue.
REQ-008 lane_in  in  3  current lane reported by the player FSM.
REQ-009 mv_left, mv_right  out  1 each  registered one-cycle move pulses to the player FSM.
REQ-010 q_count  out  3  current queue occupancy, 0..QDEPTH.
REQ-011 busy  out  1  high whenever the FSM state is not IDLE.
REQ-012 overflow  out  1  sticky flag; set when a request is dropped because the queue was full.

Function
REQ-013 A rising edge of a button is detected when the button is sampled high at a clk edge and was sampled low at the previous edge; a request is pushed at that same edge.
REQ-014 Left and right rising edges detected at the same edge cancel each other; nothing is pushed.
REQ-015 The queue is a FIFO of 1-bit directions; push and pop at the same edge are both honoured, including when the queue is full.
REQ-016 A push into a full queue with no simultaneous pop is dropped and sets overflow.
REQ-017 FSM states are IDLE, ISSUE and COOL.
REQ-018 IDLE goes to ISSUE when enable is high and q_count is nonzero.
REQ-019 ISSUE lasts one cycle and pops the queue head; the matching mv_* output is high for exactly that cycle.
REQ-020 ISSUE goes to COOL and loads a counter with COOLDOWN-1.
REQ-021 COOL decrements the counter each cycle.
REQ-022 When the COOL counter reaches zero, the FSM goes to ISSUE if enable is high and the queue is non-empty, otherwise to IDLE; issue-to-issue spacing is therefore COOLDOWN+1 cycles.
REQ-023 Latency: a mv_* pulse is visible one cycle after the push edge when the FSM is in IDLE and the queue was empty.
REQ-024 mv_left and mv_right are never high in the same cycle.
REQ-025 While enable is low, button edges are ignored, the queue is flushed to zero, ISSUE is not entered, and COOL keeps counting down to IDLE.

Reset
REQ-026 While reset is low at a clk edge: state goes to IDLE, the COOL counter to 0, the queue empties, and the button history registers clear.
REQ-027 Reset values: mv_left=0, mv_right=0, q_count=0, busy=0, overflow=0.
REQ-028 Reset asserted mid-ISSUE or mid-COOL aborts the operation, discards queued moves, and produces no pulse at the next edge.
REQ-029 overflow clears only by reset.

Configuration
REQ-030 Macro MOVE_SCHED_BOUNDARY_EN defined: in ISSUE, a left move with lane_in==0 or a right move with lane_in==NUM_LANES-1 is popped with no pulse, and the FSM returns to IDLE without cooldown.
REQ-031 MOVE_SCHED_BOUNDARY_EN undefined: every popped move pulses, and lane_in is unused.

Structure
REQ-032 Shared package lane_surfer_pkg holds NUM_LANES, the direction constants (DIR_LEFT=0, DIR_RIGHT=1) and the scheduler state typedef.
REQ-033 One sub-module, move_fifo, implements the QDEPTH x 1-bit queue with count, full and empty outputs and a flush input; the edge detect and FSM stay in move_scheduler.

Verification (COOLDOWN=8, QDEPTH=4, NUM_LANES=5, macro defined, enable=1, lane_in=2 unless noted)
REQ-034 Reset low for 2 cycles, then high -> all outputs 0 and busy=0.
REQ-035 btn_right high for 1 cycle -> one mv_right pulse one cycle after the push edge; no further pulses within 20 cycles; q_count returns to 0.
REQ-036 Six btn_right presses 2 cycles apart -> press 1 issued immediately, presses 2-5 queued, press 6 dropped -> 5 mv_right pulses 9 cycles apart, overflow=1.
REQ-037 lane_in=0, btn_left press -> no mv_left pulse, busy high for 1 cycle only; then btn_right press -> mv_right issued with no cooldown wait.
REQ-038 btn_left and btn_right rising at the same edge -> q_count stays 0 and no pulse is produced.
REQ-039 Three presses queued, enable dropped during COOL -> q_count=0 next cycle, no further pulses, busy falls after COOL ends.
